// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder
// Pipelined carry-lookahead adder/subtractor for the FIR datapath.
// WIDTH must be a multiple of 4, and WIDTH/4 must be divisible by GPS.
// Each pipeline stage resolves GPS 4-bit lookahead groups. The carry between
// stage clusters is registered.
// Optional feature: define PIPELINED_CLA_ADDER_SAT_EN to clamp the sum on
// signed overflow. The clamp is applied in the final stage, so latency is unchanged.
//
// Handshake (valid/ready):
// - A beat is accepted on a rising edge where in_valid && in_ready.
// - A result transfers on a rising edge where out_valid && out_ready.
// - in_ready = !out_valid || out_ready. It is the single advance enable for
//   every stage register, so the whole pipe moves or freezes as one unit.
// - While a result is held (out_valid && !out_ready), sum, c_out and ovf
//   stay stable.
// - Bubbles travel with the pipe and are never compressed.
//
// Pipe layout:
// - Rank 0 captures the operands. B is inverted for subtract, and the
//   effective carry-in is folded in.
// - Rank r (1..L) holds the sum bits resolved so far, and the carry into the
//   next cluster.
// - Rank L is the output register.
// - A beat accepted at edge n therefore appears after edge n+L.
module pipelined_cla_adder #(
  parameter int WIDTH = 16,
  parameter int GPS   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int NG = WIDTH / 4;   // number of 4-bit lookahead groups
  localparam int L  = NG / GPS;    // pipeline latency in stages

  // Per-rank state: valid bit, carry into next cluster, partial sum
  logic [L:0]       v_q, v_d;
  logic [L:0]       c_q, c_d;
  logic [WIDTH-1:0] s_q [0:L];
  logic [WIDTH-1:0] s_d [0:L];
  // Operands (B already inverted when subtracting) travel alongside the carry
  logic [WIDTH-1:0] a_q [0:L-1];
  logic [WIDTH-1:0] a_d [0:L-1];
  logic [WIDTH-1:0] b_q [0:L-1];
  logic [WIDTH-1:0] b_d [0:L-1];
  logic             ovf_q, ovf_d;

  // Scratch signals for the carry chain inside one stage
  logic             carry;
  logic [WIDTH-1:0] acc;
  logic [4:0]       res;
  logic             raw_msb;
  logic             en;

  // 4-bit lookahead group: returns {carry_out, sum[3:0]}
  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                      input logic ci);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = a & b;
    p    = a ^ b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c[4], p ^ c[3:0]};
  endfunction

  // Global advance enable: the pipe moves unless a held result blocks it
  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign out_valid = v_q[L];
  assign sum       = s_q[L];
  assign c_out     = c_q[L];
  assign ovf       = ovf_q;

  // Next-state for every rank: operand capture, then group resolution per stage
  always_comb begin
    carry   = 1'b0;
    acc     = '0;
    res     = '0;
    raw_msb = 1'b0;
    ovf_d   = 1'b0;

    // Rank 0: subtract is A + ~B + 1, so c_in is ignored when sub=1
    v_d[0] = in_valid;
    c_d[0] = sub | c_in;
    s_d[0] = '0;
    a_d[0] = a_in;
    b_d[0] = sub ? ~b_in : b_in;

    // Ranks 1..L: stage r-1 resolves groups (r-1)*GPS .. (r-1)*GPS+GPS-1
    for (int r = 1; r <= L; r++) begin
      v_d[r] = v_q[r-1];
      carry  = c_q[r-1];
      acc    = s_q[r-1];
      for (int j = 0; j < GPS; j++) begin
        res = cla4(a_q[r-1][4*((r-1)*GPS+j) +: 4], b_q[r-1][4*((r-1)*GPS+j) +: 4], carry);
        acc[4*((r-1)*GPS+j) +: 4] = res[3:0];
        carry = res[4];
      end
      c_d[r] = carry;
      s_d[r] = acc;
    end

    // Unresolved operand bits are delayed alongside the carry
    for (int r = 1; r < L; r++) begin
      a_d[r] = a_q[r-1];
      b_d[r] = b_q[r-1];
    end

    // Signed overflow: operands agree in sign but the raw result does not
    raw_msb = s_d[L][WIDTH-1];
    ovf_d   = (a_q[L-1][WIDTH-1] == b_q[L-1][WIDTH-1]) && (raw_msb != a_q[L-1][WIDTH-1]);

`ifdef PIPELINED_CLA_ADDER_SAT_EN
    // Clamp on overflow: raw MSB set means the true result was positive
    if (ovf_d) begin
      s_d[L] = raw_msb ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
    end
`endif
  end

  // Pipeline registers:
  // - every rank advances only on en
  // - data loads only behind a valid beat, so bubbles leave it untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int r = 0; r <= L; r++) begin
        s_q[r] <= '0;
      end
      for (int r = 0; r < L; r++) begin
        a_q[r] <= '0;
        b_q[r] <= '0;
      end
    end else if (en) begin
      v_q <= v_d;
      for (int r = 0; r <= L; r++) begin
        if (v_d[r]) begin
          c_q[r] <= c_d[r];
          s_q[r] <= s_d[r];
        end
      end
      for (int r = 0; r < L; r++) begin
        if (v_d[r]) begin
          a_q[r] <= a_d[r];
          b_q[r] <= b_d[r];
        end
      end
      if (v_d[L]) begin
        ovf_q <= ovf_d;
      end
    end
  end

endmodule
